// File: rtl/wb_regfile_pkg.sv
// Shared widths, register-zero index and write-back source encoding
// for the MEM/WB write-back stage and its register file.
package wb_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_src_e;

    // Link address outranks the memory result.
    function automatic wb_src_e wb_src_sel(input logic pcto, input logic memto);
        wb_src_e s;
        s = WB_ALU;
        if (pcto) begin
            s = WB_PC;
        end else if (memto) begin
            s = WB_MEM;
        end
        return s;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bundle plus the decode-stage read ports.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W
);
    logic              MEM_WB_RegWrite;
    logic              MEM_WB_MemtoReg;
    logic              MEM_WB_PctoReg;
    logic [DATA_W-1:0] MEM_WB_pc_add_out;
    logic [DATA_W-1:0] MEM_WB_dm_out;
    logic [DATA_W-1:0] MEM_WB_alu_out;
    logic [ADDR_W-1:0] MEM_WB_mux1_out;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic [31:0]       retire_count;

    modport master (
        output MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_PctoReg,
        output MEM_WB_pc_add_out, MEM_WB_dm_out, MEM_WB_alu_out,
        output MEM_WB_mux1_out, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_en, retire_count
    );

    modport slave (
        input  MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_PctoReg,
        input  MEM_WB_pc_add_out, MEM_WB_dm_out, MEM_WB_alu_out,
        input  MEM_WB_mux1_out, rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_en, retire_count
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register storage; entry zero is hardwired to 0.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != ZERO_REG)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = (raddr_a == ZERO_REG) ? '0 : regs_q[raddr_a];
        rdata_b = (raddr_b == ZERO_REG) ? '0 : regs_q[raddr_b];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: source select, register file with write-before-read
// bypass, and a count of committed register writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
    input logic   clock,
    input logic   reset,
    wb_regfile_if.slave bus
);
    wb_src_e           src;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [31:0]       retire_q;
    logic [31:0]       retire_d;

    always_comb begin
        src = wb_src_sel(bus.MEM_WB_PctoReg, bus.MEM_WB_MemtoReg);
        unique case (src)
            WB_PC:   wb_data = bus.MEM_WB_pc_add_out;
            WB_MEM:  wb_data = bus.MEM_WB_dm_out;
            default: wb_data = bus.MEM_WB_alu_out;
        endcase
        wb_en = bus.MEM_WB_RegWrite && (bus.MEM_WB_mux1_out != ZERO_REG);
    end

    regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
        .clock   (clock),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (bus.MEM_WB_mux1_out),
        .wdata   (wb_data),
        .raddr_a (bus.rs_addr),
        .raddr_b (bus.rt_addr),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // Bypass lets decode see the value committing at this edge.
    always_comb begin
        bus.rs_data = rf_a;
        bus.rt_data = rf_b;
        if (wb_en && (bus.rs_addr == bus.MEM_WB_mux1_out)) begin
            bus.rs_data = wb_data;
        end
        if (wb_en && (bus.rt_addr == bus.MEM_WB_mux1_out)) begin
            bus.rt_data = wb_data;
        end
        bus.wb_data      = wb_data;
        bus.wb_en        = wb_en;
        bus.retire_count = retire_q;
    end

    always_comb begin
        retire_d = retire_q;
        if (wb_en) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, 32, data path width in bits; all data ports and registers SHALL use this width.
REQ-002 Parameter ADDR_W, 5, register address width; the file SHALL hold 2^ADDR_W registers.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MEM_WB_RegWrite  input  1  write-back enable from the MEM/WB register.
REQ-006 MEM_WB_MemtoReg  input  1  selects data-memory result for write-back.
REQ-007 MEM_WB_PctoReg  input  1  selects the link address (PC+4) for write-back.
REQ-008 MEM_WB_pc_add_out  input  DATA_W  link address.
REQ-009 MEM_WB_dm_out  input  DATA_W  data-memory read result.
REQ-010 MEM_WB_alu_out  input  DATA_W  ALU result.
REQ-011 MEM_WB_mux1_out  input  ADDR_W  destination register number.
REQ-012 rs_addr, rt_addr  input  ADDR_W each  decode-stage read addresses.
REQ-013 rs_data, rt_data  output  DATA_W each  combinational read data.
REQ-014 wb_data  output  DATA_W  selected write-back value, for EX-stage forwarding.
REQ-015 wb_en  output  1  high when a register write commits at the next edge.
REQ-016 retire_count  output  32  count of committed register writes.

Function
REQ-017 wb_data SHALL be MEM_WB_pc_add_out when PctoReg=1, else MEM_WB_dm_out when MemtoReg=1, else MEM_WB_alu_out; PctoReg has priority.
REQ-018 wb_en SHALL equal MEM_WB_RegWrite AND (MEM_WB_mux1_out != 0).
REQ-019 When wb_en=1, register[MEM_WB_mux1_out] SHALL take wb_data at the rising edge; otherwise no register changes.
REQ-020 Register 0 SHALL never be written and SHALL read as 0 on both ports.
REQ-021 Read ports SHALL be combinational, with zero cycles of latency.
REQ-022 Bypass: when wb_en=1 and a read address equals MEM_WB_mux1_out, that port SHALL return wb_data in the same cycle, so write-before-read holds.
REQ-023 Both ports reading the same address SHALL return identical data, with or without bypass.
REQ-024 retire_count SHALL increment by 1 on each edge where wb_en=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 A write with RegWrite=1 and destination 0 SHALL change no state and SHALL NOT increment retire_count.

Reset
REQ-026 reset=1 SHALL immediately, without a clock edge, clear all registers and retire_count to 0.
REQ-027 While reset=1, writes SHALL be suppressed even if wb_en=1.
REQ-028 While reset=1, rs_data and rt_data SHALL read 0 for non-bypassed addresses.
REQ-029 A reset asserted mid-operation SHALL discard the pending write, and the first post-reset edge SHALL behave normally.

Structure
REQ-030 A shared package SHALL hold DATA_W, ADDR_W, the ZERO_REG index, and the write-back source encoding (ALU, MEM, PC).
REQ-031 The storage array SHALL be one sub-module, regfile_2r1w, with two read ports and one write port; select and bypass logic SHALL stay in wb_regfile.

Verification
REQ-032 Reset, then read all 32 addresses -> every read returns 0 and retire_count=0.
REQ-033 RegWrite=1, dest=5, alu_out=0x1234, MemtoReg=0, PctoReg=0, rs_addr=5 in the same cycle -> rs_data=0x1234 via bypass; after the edge reg5=0x1234 and retire_count=1.
REQ-034 RegWrite=1, dest=31, PctoReg=1, MemtoReg=1, pc_add_out=0x400008, dm_out=0xDEAD -> wb_data=0x400008 and reg31=0x400008.
REQ-035 RegWrite=1, dest=0, alu_out=0xFFFFFFFF -> rs_addr=0 reads 0, wb_en=0, retire_count unchanged.
REQ-036 Preload retire_count to 0xFFFFFFFF by forced state, then one commit -> retire_count=0.
REQ-037 Assert reset between clock edges while RegWrite=1, dest=7 -> reg7=0 immediately and stays 0 after the next edge.
